// File: rtl/bls12_381_pkg.sv
// Shared field definitions for the bls12_381 core: element type, modulus, inverter mode
// and reference arithmetic helpers for the field units.
package bls12_381_pkg;

    localparam int DAT_BITS = 381;

    typedef logic [DAT_BITS-1:0] fe_t;

    localparam fe_t P = 381'h1a0111ea_397fe69a_4b1ba7b6_434bacd7_64774b84_f38512bf_6730d2a0_f6b0f624_1eabfffe_b153ffff_b9feffff_ffffaaab;

    typedef enum logic {
        INV = 1'b0,
        DIV = 1'b1
    } inv_mode_t;

    // Worst-case reduction steps of the binary extended Euclid over DAT_BITS operands.
    localparam int INV_MAX_ITER = 4*DAT_BITS + 4;

    function automatic fe_t fe_mul(input fe_t a, input fe_t b);
        logic [2*DAT_BITS-1:0] prod;
        prod = {{DAT_BITS{1'b0}}, a} * {{DAT_BITS{1'b0}}, b};
        return fe_t'(prod % {{DAT_BITS{1'b0}}, P});
    endfunction

    // Fermat inverse a^(P-2); independent of the Euclid datapath it is used to check.
    function automatic fe_t fe_inv(input fe_t a);
        fe_t e;
        fe_t r;
        e = P - fe_t'(2);
        r = fe_t'(1);
        for (int i = DAT_BITS-1; i >= 0; i--) begin
            r = fe_mul(r, r);
            if (e[i]) r = fe_mul(r, a);
        end
        return r;
    endfunction

endpackage

// File: rtl/fe_bin_half_sub.sv
// Purpose: modular halve and modular subtract for one Bezout coefficient of the inverter.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of x and y.
module fe_bin_half_sub #(
    parameter int                  DAT_BITS = bls12_381_pkg::DAT_BITS,
    parameter logic [DAT_BITS-1:0] P        = bls12_381_pkg::P
) (
    input  logic [DAT_BITS:0] x,
    input  logic [DAT_BITS:0] y,
    output logic [DAT_BITS:0] half,
    output logic [DAT_BITS:0] diff
);

    logic [DAT_BITS:0] p_ext;
    logic [DAT_BITS:0] x_plus_p;

    assign p_ext    = {1'b0, P};
    // x stays below 2^DAT_BITS, so the extra bit is enough to hold x+P before the shift.
    assign x_plus_p = x + p_ext;

    always_comb begin
        half = x[0] ? (x_plus_p >> 1) : (x >> 1);
        // Wrap-around in DAT_BITS+1 bits is harmless: the true x-y+P is non-negative.
        diff = (x >= y) ? (x - y) : (x - y + p_ext);
    end

endmodule

// File: rtl/fe_bin_inv_div.sv
// Purpose: modular inverse (INV) or quotient b/a (DIV) mod P by binary extended Euclid.
// Latency: 3 cycles for a==1, 2 for rejected operands, at most MAX_ITER+3 otherwise.
// Backpressure: one request in flight; result held in DONE until i_rdy, o_rdy low meanwhile.
module fe_bin_inv_div #(
    parameter int                  DAT_BITS = bls12_381_pkg::DAT_BITS,
    parameter logic [DAT_BITS-1:0] P        = bls12_381_pkg::P,
    parameter int                  CTL_BITS = 8,
    parameter int                  MAX_ITER = 4*DAT_BITS + 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_val,
    output logic                        o_rdy,
    input  logic [DAT_BITS-1:0]         i_a,
    input  logic [DAT_BITS-1:0]         i_b,
    input  bls12_381_pkg::inv_mode_t    i_mode,
    input  logic [CTL_BITS-1:0]         i_ctl,
    output logic                        o_val,
    input  logic                        i_rdy,
    output logic [DAT_BITS-1:0]         o_dat,
    output logic                        o_err,
    output logic [CTL_BITS-1:0]         o_ctl
);

    localparam int XW       = DAT_BITS + 1;
    localparam int CNT_BITS = $clog2(MAX_ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [DAT_BITS-1:0]   u, u_nxt;
    logic [DAT_BITS-1:0]   v, v_nxt;
    logic [XW-1:0]         x1, x1_nxt;
    logic [XW-1:0]         x2, x2_nxt;
    logic [CNT_BITS-1:0]   cnt, cnt_nxt;
    logic [DAT_BITS-1:0]   dat_q, dat_nxt;
    logic                  err_q, err_nxt;
    logic [CTL_BITS-1:0]   ctl_q, ctl_nxt;

    logic [XW-1:0]         x1_half, x1_diff;
    logic [XW-1:0]         x2_half, x2_diff;

    fe_bin_half_sub #(
        .DAT_BITS (DAT_BITS),
        .P        (P)
    ) u_x1_path (
        .x    (x1),
        .y    (x2),
        .half (x1_half),
        .diff (x1_diff)
    );

    fe_bin_half_sub #(
        .DAT_BITS (DAT_BITS),
        .P        (P)
    ) u_x2_path (
        .x    (x2),
        .y    (x1),
        .half (x2_half),
        .diff (x2_diff)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            u     <= '0;
            v     <= '0;
            x1    <= '0;
            x2    <= '0;
            cnt   <= '0;
            dat_q <= '0;
            err_q <= 1'b0;
            ctl_q <= '0;
        end else begin
            state <= state_nxt;
            u     <= u_nxt;
            v     <= v_nxt;
            x1    <= x1_nxt;
            x2    <= x2_nxt;
            cnt   <= cnt_nxt;
            dat_q <= dat_nxt;
            err_q <= err_nxt;
            ctl_q <= ctl_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        u_nxt     = u;
        v_nxt     = v;
        x1_nxt    = x1;
        x2_nxt    = x2;
        cnt_nxt   = cnt;
        dat_nxt   = dat_q;
        err_nxt   = err_q;
        ctl_nxt   = ctl_q;

        case (state)
            IDLE: begin
                if (i_val) begin
                    ctl_nxt = i_ctl;
                    u_nxt   = i_a;
                    v_nxt   = P;
                    x1_nxt  = (i_mode == bls12_381_pkg::INV) ? XW'(1) : {1'b0, i_b};
                    x2_nxt  = '0;
                    cnt_nxt = '0;
                    if ((i_a == '0) || (i_a >= P)) begin
                        dat_nxt   = '0;
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end

            RUN: begin
                // Invariants: x1*a == u*b0 and x2*a == v*b0 (mod P), so u==1 yields x1.
                if (u == DAT_BITS'(1)) begin
                    dat_nxt   = x1[DAT_BITS-1:0];
                    state_nxt = DONE;
                end else if (v == DAT_BITS'(1)) begin
                    dat_nxt   = x2[DAT_BITS-1:0];
                    state_nxt = DONE;
                end else if (cnt == CNT_BITS'(MAX_ITER)) begin
                    dat_nxt   = '0;
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_BITS'(1);
                    if (!u[0]) begin
                        u_nxt  = u >> 1;
                        x1_nxt = x1_half;
                    end else if (!v[0]) begin
                        v_nxt  = v >> 1;
                        x2_nxt = x2_half;
                    end else if (u >= v) begin
                        u_nxt  = u - v;
                        x1_nxt = x1_diff;
                    end else begin
                        v_nxt  = v - u;
                        x2_nxt = x2_diff;
                    end
                end
            end

            DONE: begin
                if (i_rdy) begin
                    err_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign o_rdy = (state == IDLE);
    assign o_val = (state == DONE);
    assign o_dat = dat_q;
    assign o_err = err_q;
    assign o_ctl = ctl_q;

endmodule

// File: tb/tb_fe_bin_inv_div.sv
// Bench for fe_bin_inv_div: a P=13 toy instance and a full bls12_381 instance side by side,
// with a per-request expectation queue checked by one compare process.
module tb_fe_bin_inv_div;
    import bls12_381_pkg::*;

    localparam int S_MAX_LAT = 4*4 + 4 + 3;
    localparam int B_MAX_LAT = INV_MAX_ITER + 3;

    typedef struct {
        int         side;
        fe_t        dat;
        logic       err;
        logic [7:0] ctl;
        int         exact;
        int         acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    // small instance (side 0)
    logic       s_i_val, s_o_rdy, s_o_val, s_i_rdy, s_o_err;
    logic [3:0] s_i_a, s_i_b, s_o_dat;
    inv_mode_t  s_i_mode;
    logic [7:0] s_i_ctl, s_o_ctl;
    // full-width instance (side 1)
    logic       b_i_val, b_o_rdy, b_o_val, b_i_rdy, b_o_err;
    fe_t        b_i_a, b_i_b, b_o_dat;
    inv_mode_t  b_i_mode;
    logic [7:0] b_i_ctl, b_o_ctl;

    fe_bin_inv_div #(.DAT_BITS(4), .P(4'd13), .CTL_BITS(8)) u_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_val(s_i_val), .o_rdy(s_o_rdy),
        .i_a(s_i_a), .i_b(s_i_b), .i_mode(s_i_mode), .i_ctl(s_i_ctl),
        .o_val(s_o_val), .i_rdy(s_i_rdy), .o_dat(s_o_dat), .o_err(s_o_err), .o_ctl(s_o_ctl)
    );

    fe_bin_inv_div u_big (
        .i_clk(clk), .i_rst_n(rst_n), .i_val(b_i_val), .o_rdy(b_o_rdy),
        .i_a(b_i_a), .i_b(b_i_b), .i_mode(b_i_mode), .i_ctl(b_i_ctl),
        .o_val(b_o_val), .i_rdy(b_i_rdy), .o_dat(b_o_dat), .o_err(b_o_err), .o_ctl(b_o_ctl)
    );

    logic       iv[2], ordy[2], ov[2], irdy[2], oerr[2];
    fe_t        odat[2];
    logic [7:0] octl[2];
    assign iv[0] = s_i_val;   assign iv[1] = b_i_val;
    assign ordy[0] = s_o_rdy; assign ordy[1] = b_o_rdy;
    assign ov[0] = s_o_val;   assign ov[1] = b_o_val;
    assign irdy[0] = s_i_rdy; assign irdy[1] = b_i_rdy;
    assign oerr[0] = s_o_err; assign oerr[1] = b_o_err;
    assign odat[0] = {{(DAT_BITS-4){1'b0}}, s_o_dat};
    assign odat[1] = b_o_dat;
    assign octl[0] = s_o_ctl; assign octl[1] = b_o_ctl;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL global_timeout checks=%0d", n_chk);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input fe_t got, input fe_t want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int small_inv(input int a);
        for (int x = 1; x < 13; x++)
            if ((a * x) % 13 == 1) return x;
        return 0;
    endfunction

    task automatic model(input int k, input fe_t a, input fe_t b, input inv_mode_t mode,
                         output fe_t dat, output logic err);
        int ai, bi, inv;
        dat = '0;
        err = 1'b0;
        if (k == 0) begin
            ai = int'(a[3:0]);
            bi = int'(b[3:0]);
            if (ai == 0 || ai >= 13) err = 1'b1;
            else begin
                inv = small_inv(ai);
                dat = fe_t'((mode == INV) ? inv : (bi * inv) % 13);
            end
        end else begin
            if (a == '0 || a >= P) err = 1'b1;
            else dat = (mode == INV) ? fe_inv(a) : fe_mul(b, fe_inv(a));
        end
    endtask

    // ---------------- compare process ----------------
    bit         seen[2];
    fe_t        snap_dat[2];
    logic       snap_err[2];
    logic [7:0] snap_ctl[2];

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                int idx;
                int lat;
                bit marked;
                idx = -1;
                marked = 0;
                if (iv[k] && ordy[k]) begin
                    for (int i = 0; i < exp_q.size(); i++)
                        if (!marked && exp_q[i].side == k && exp_q[i].acc < 0) begin
                            exp_q[i].acc = cyc;
                            marked = 1;
                        end
                end
                for (int i = 0; i < exp_q.size(); i++)
                    if (idx < 0 && exp_q[i].side == k) idx = i;
                if (ov[k]) begin
                    chk(k == 0 ? "s_rdy_in_done" : "b_rdy_in_done", fe_t'(ordy[k]), fe_t'(0));
                    if (idx < 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL spurious_val side=%0d got=1 want=0", k);
                    end else begin
                        if (!seen[k]) begin
                            seen[k] = 1;
                            snap_dat[k] = odat[k];
                            snap_err[k] = oerr[k];
                            snap_ctl[k] = octl[k];
                            lat = cyc - exp_q[idx].acc + 1;
                            n_chk++;
                            if (exp_q[idx].acc < 0 ||
                                (exp_q[idx].exact > 0 && lat != exp_q[idx].exact) ||
                                lat > (k == 0 ? S_MAX_LAT : B_MAX_LAT)) begin
                                n_fail++;
                                $display("FAIL latency side=%0d got=%0d want=%0d", k, lat, exp_q[idx].exact);
                            end
                        end else begin
                            chk(k == 0 ? "s_hold_dat" : "b_hold_dat", odat[k], snap_dat[k]);
                            chk(k == 0 ? "s_hold_err" : "b_hold_err", fe_t'(oerr[k]), fe_t'(snap_err[k]));
                            chk(k == 0 ? "s_hold_ctl" : "b_hold_ctl", fe_t'(octl[k]), fe_t'(snap_ctl[k]));
                        end
                        if (irdy[k]) begin
                            chk(k == 0 ? "s_res_dat" : "b_res_dat", odat[k], exp_q[idx].dat);
                            chk(k == 0 ? "s_res_err" : "b_res_err", fe_t'(oerr[k]), fe_t'(exp_q[idx].err));
                            chk(k == 0 ? "s_res_ctl" : "b_res_ctl", fe_t'(octl[k]), fe_t'(exp_q[idx].ctl));
                            exp_q.delete(idx);
                            seen[k] = 0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    function automatic int pending(input int k);
        int n;
        n = 0;
        foreach (exp_q[i]) if (exp_q[i].side == k) n++;
        return n;
    endfunction

    task automatic purge(input int k);
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].side == k) exp_q.delete(i);
        seen[k] = 0;
    endtask

    task automatic send(input int k, input fe_t a, input fe_t b, input inv_mode_t mode,
                        input logic [7:0] ctl, input fe_t edat, input logic eerr, input int exact);
        exp_t e;
        bit   got, r;
        e.side = k; e.dat = edat; e.err = eerr; e.ctl = ctl; e.exact = exact; e.acc = -1;
        exp_q.push_back(e);
        if (k == 0) begin
            s_i_a = a[3:0]; s_i_b = b[3:0]; s_i_mode = mode; s_i_ctl = ctl; s_i_val = 1'b1;
        end else begin
            b_i_a = a; b_i_b = b; b_i_mode = mode; b_i_ctl = ctl; b_i_val = 1'b1;
        end
        got = 0;
        for (int c = 0; c < 8000 && !got; c++) begin
            r = ordy[k];
            @(posedge clk);
            #1;
            if (r) got = 1;
        end
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout side=%0d got=0 want=1", k);
            if (k == 0) s_i_val = 1'b0; else b_i_val = 1'b0;
        end
    endtask

    task automatic send_m(input int k, input fe_t a, input fe_t b, input inv_mode_t mode,
                          input logic [7:0] ctl);
        fe_t  d;
        logic e;
        model(k, a, b, mode, d, e);
        send(k, a, b, mode, ctl, d, e, e ? 2 : 0);
    endtask

    task automatic idle(input int k);
        if (k == 0) s_i_val = 1'b0; else b_i_val = 1'b0;
    endtask

    task automatic wait_side(input int k);
        int c;
        c = 0;
        while (pending(k) > 0 && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (pending(k) > 0) begin
            n_chk++; n_fail++;
            $display("FAIL result_timeout side=%0d pending=%0d want=0", k, pending(k));
            purge(k);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_rdy"}, fe_t'(ordy[k]), fe_t'(1));
            chk({tag, "_val"}, fe_t'(ov[k]), fe_t'(0));
            chk({tag, "_dat"}, odat[k], fe_t'(0));
            chk({tag, "_err"}, fe_t'(oerr[k]), fe_t'(0));
            chk({tag, "_ctl"}, fe_t'(octl[k]), fe_t'(0));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [383:0] r;
        logic [383:0] rm;
        fe_t          a;
        int           c;

        rst_n = 1'b0;
        s_i_val = 1'b0; s_i_a = '0; s_i_b = '0; s_i_mode = INV; s_i_ctl = '0; s_i_rdy = 1'b1;
        b_i_val = 1'b0; b_i_a = '0; b_i_b = '0; b_i_mode = INV; b_i_ctl = '0; b_i_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // pin the reference model with hand-derived values
        chk("model_small_inv3", fe_t'(small_inv(3)), fe_t'(9));
        chk("model_small_inv7", fe_t'(small_inv(7)), fe_t'(2));
        chk("model_big_inv2", fe_inv(fe_t'(2)), (P + fe_t'(1)) >> 1);
        chk("model_big_div", fe_mul(fe_t'(6), fe_inv(fe_t'(2))), fe_t'(3));

        // P=13 literals, errors, sweep
        send(0, 3, 0, INV, 8'h11, 9, 1'b0, 0); idle(0); wait_side(0);
        send(0, 3, 5, DIV, 8'h12, 6, 1'b0, 0); idle(0); wait_side(0);
        send(0, 1, 0, INV, 8'h13, 1, 1'b0, 3); idle(0); wait_side(0);
        send(0, 0, 0, INV, 8'h14, 0, 1'b1, 2); idle(0); wait_side(0);
        send(0, 7, 0, INV, 8'h15, 2, 1'b0, 0); idle(0); wait_side(0);
        send(0, 13, 0, INV, 8'h16, 0, 1'b1, 2); idle(0); wait_side(0);
        send(0, 15, 3, DIV, 8'h17, 0, 1'b1, 2); idle(0); wait_side(0);
        for (int i = 1; i <= 12; i++) begin
            send_m(0, fe_t'(i), 0, INV, 8'(8'h20 + i)); idle(0); wait_side(0);
        end
        for (int i = 1; i <= 12; i++) begin
            send_m(0, fe_t'(i), fe_t'(13 - i), DIV, 8'(8'h40 + i)); idle(0); wait_side(0);
        end

        // full-width literals and errors
        send(1, 1, 0, INV, 8'h01, 1, 1'b0, 3); idle(1); wait_side(1);
        send(1, 2, 0, INV, 8'h02, (P + fe_t'(1)) >> 1, 1'b0, 0); idle(1); wait_side(1);
        send(1, P - fe_t'(1), 0, INV, 8'h03, P - fe_t'(1), 1'b0, 0); idle(1); wait_side(1);
        send(1, 2, 6, DIV, 8'h04, 3, 1'b0, 0); idle(1); wait_side(1);
        send(1, 0, 0, INV, 8'h05, 0, 1'b1, 2); idle(1); wait_side(1);
        send(1, P, 0, INV, 8'h06, 0, 1'b1, 2); idle(1); wait_side(1);
        send_m(1, 5, 0, INV, 8'h07); idle(1); wait_side(1);
        for (int n = 0; n < 12; n++) begin
            for (int w = 0; w < 12; w++) r[32*w +: 32] = $urandom;
            rm = r % {3'b000, P};
            a = rm[DAT_BITS-1:0];
            if (a == '0) a = fe_t'(1);
            send_m(1, a, 0, INV, 8'(8'h80 + n)); idle(1); wait_side(1);
        end

        // backpressure in DONE
        b_i_rdy = 1'b0;
        send_m(1, 3, 0, INV, 8'hA5); idle(1);
        c = 0;
        while (!ov[1] && c < 2000) begin @(posedge clk); #1; c++; end
        repeat (20) begin @(posedge clk); #1; end
        chk("bp_val_held", fe_t'(ov[1]), fe_t'(1));
        chk("bp_rdy_low", fe_t'(ordy[1]), fe_t'(0));
        b_i_rdy = 1'b1;
        @(posedge clk); #1;
        chk("bp_val_drop", fe_t'(ov[1]), fe_t'(0));
        chk("bp_rdy_back", fe_t'(ordy[1]), fe_t'(1));
        wait_side(1);

        // asynchronous reset in the middle of a run
        send(0, 7, 0, INV, 8'h77, 2, 1'b0, 0); idle(0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        purge(0);
        check_reset_vals("arst");
        repeat (2) begin @(posedge clk); #1; end
        chk("arst_no_val", fe_t'(s_o_val), fe_t'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, 7, 0, INV, 8'h78, 2, 1'b0, 0); idle(0); wait_side(0);

        // back-to-back with i_val held high
        send_m(0, 2, 0, INV, 8'hB0);
        send_m(0, 4, 0, INV, 8'hB1);
        send_m(0, 5, 9, DIV, 8'hB2);
        send_m(0, 11, 0, INV, 8'hB3);
        idle(0);
        wait_side(0);
        repeat (5) begin @(posedge clk); #1; end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
